// File: rtl/qdq_dq_tile_arbiter_if.sv
// ---------------------------------------------------------------------------
// qdq_dq_tile_arbiter_if
//
// Purpose:
//   Bundles the requester-side and dequantizer-side streaming signals of the
//   QDQ dequantize tile arbiter. There are NUM_REQ accumulator tile sources
//   and one beat stream toward the dequantizer.
//
// Signals:
//   req_valid  [NUM_REQ]                      per-requester beat valid
//   req_ready  [NUM_REQ]                      per-requester beat ready
//   req_data   [NUM_REQ*LANES_NUM*FP_DATA_W]  requester r data at slice r
//   dq_valid                                  beat valid to dequantizer
//   dq_ready                                  dequantizer ready
//   dq_tfirst                                 first beat of a tile
//   dq_tlast                                  last beat of a tile
//   dq_data    [LANES_NUM*FP_DATA_W]          muxed beat data
//
// Modports:
//   master : the arbiter (consumes requester beats, drives the dequantizer)
//   slave  : the environment (requesters plus dequantizer)
// ---------------------------------------------------------------------------
interface qdq_dq_tile_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int LANES_NUM = 16,
    parameter int FP_DATA_W = 32
);
    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ*LANES_NUM*FP_DATA_W-1:0] req_data;
    logic                                   dq_valid;
    logic                                   dq_ready;
    logic                                   dq_tfirst;
    logic                                   dq_tlast;
    logic [LANES_NUM*FP_DATA_W-1:0]         dq_data;

    modport master (
        input  req_valid,
        input  req_data,
        input  dq_ready,
        output req_ready,
        output dq_valid,
        output dq_tfirst,
        output dq_tlast,
        output dq_data
    );

    modport slave (
        output req_valid,
        output req_data,
        output dq_ready,
        input  req_ready,
        input  dq_valid,
        input  dq_tfirst,
        input  dq_tlast,
        input  dq_data
    );
endinterface

// File: rtl/qdq_dq_tile_arbiter.sv
// ---------------------------------------------------------------------------
// qdq_dq_tile_arbiter
//
// Purpose:
//   Shares the single dequantize path between NUM_REQ accumulator tile
//   sources. A requester is granted for a whole tile of BEATS beats, chosen
//   round-robin, and the beats are forwarded with tfirst/tlast markers. Every
//   grant consumes one scale credit; a credit is added per scale set pushed
//   into the scale FIFO, so a tile never starts before its scale matrix is
//   available.
//
// Ports:
//   clk          clock
//   rstnn        asynchronous reset, active-low
//   flush_i      synchronous flush of all state (beats every other event)
//   scl_push_i   one-cycle pulse: one scale set written to the scale FIFO
//   bus          master side of qdq_dq_tile_arbiter_if (requesters + dq)
//   grant_id_o   current / last granted requester
//   credit_o     available scale credits
//   busy_o       1 while a tile is being transferred
//   err_o        sticky: scale push received while credits were full
// ---------------------------------------------------------------------------
module qdq_dq_tile_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int LANES_NUM  = 16,
    parameter  int FP_DATA_W  = 32,
    parameter  int MAT_SIZE   = 16,
    parameter  int CREDIT_MAX = 4,
    localparam int BEATS      = (MAT_SIZE * MAT_SIZE + LANES_NUM - 1) / LANES_NUM,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CRED_W     = $clog2(CREDIT_MAX + 1),
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int DATA_W     = LANES_NUM * FP_DATA_W
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  flush_i,
    input  logic                  scl_push_i,
    qdq_dq_tile_arbiter_if.master bus,
    output logic [ID_W-1:0]       grant_id_o,
    output logic [CRED_W-1:0]     credit_o,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    grant_q;
    logic [ID_W-1:0]    rr_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [CRED_W-1:0]  credit_q;
    logic               err_q;

    logic [ID_W-1:0]    pick;
    logic               pick_found;
    logic [ID_W-1:0]    scan_id;
    int                 scan_idx;

    logic               grant_w;
    logic               cur_valid;
    logic               hs_w;
    logic               last_w;

    // Round-robin pick: walk the requesters starting at rr_q and take the
    // first one showing valid. The scan wraps with a subtract rather than a
    // modulo so NUM_REQ does not have to be a power of two.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = 0;
        scan_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(rr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            scan_id = ID_W'(scan_idx);
            if (!pick_found && bus.req_valid[scan_id]) begin
                pick_found = 1'b1;
                pick       = scan_id;
            end
        end
    end

    // A grant needs the arbiter idle, at least one scale credit and some
    // requester with a beat ready to go. During a transfer the granted
    // requester keeps the lock even if it drops valid for a while.
    always_comb begin
        grant_w   = (state_q == ST_IDLE) && (credit_q != '0) && pick_found;
        cur_valid = bus.req_valid[grant_q];
        hs_w      = (state_q == ST_XFER) && cur_valid && bus.dq_ready;
        last_w    = (beat_q == BEAT_W'(BEATS - 1));
    end

    // Next-state logic: IDLE moves to XFER on a grant, XFER returns to IDLE
    // after the handshake of the last beat, which gives one idle bubble
    // between consecutive tiles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_w) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (hs_w && last_w) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stream outputs are purely combinational from the registered grant so
    // the dequantizer sees the requester's valid/data in the same cycle.
    // Everything is held at zero while idle.
    always_comb begin
        bus.dq_valid  = 1'b0;
        bus.dq_tfirst = 1'b0;
        bus.dq_tlast  = 1'b0;
        bus.dq_data   = '0;
        bus.req_ready = '0;
        if (state_q == ST_XFER) begin
            bus.dq_valid           = cur_valid;
            bus.dq_tfirst          = cur_valid && (beat_q == '0);
            bus.dq_tlast           = cur_valid && last_w;
            bus.req_ready[grant_q] = bus.dq_ready;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (grant_q == ID_W'(r)) begin
                    bus.dq_data = bus.req_data[r*DATA_W +: DATA_W];
                end
            end
        end
    end

    // State register. Flush is synchronous and wins over any grant or
    // end-of-tile transition, abandoning a tile without a tlast.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q <= ST_IDLE;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant id, round-robin pointer and beat counter. The grant id is not
    // touched by a flush so software can still see who was last served.
    // The pointer advances past the served requester only when its tile
    // completes normally.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else if (flush_i) begin
            rr_q    <= '0;
            beat_q  <= '0;
        end else if (grant_w) begin
            grant_q <= pick;
            beat_q  <= '0;
        end else if (hs_w) begin
            if (last_w) begin
                beat_q <= '0;
                rr_q   <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Scale credit bookkeeping. A push and a grant in the same cycle cancel
    // out. A lone push at full credit cannot be stored: credit stays put and
    // the sticky error flag records the overflow. Underflow is impossible
    // because a grant already requires a nonzero credit.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            credit_q <= '0;
            err_q    <= 1'b0;
        end else if (flush_i) begin
            credit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case ({scl_push_i, grant_w})
                2'b10: begin
                    if (credit_q == CRED_W'(CREDIT_MAX)) begin
                        err_q <= 1'b1;
                    end else begin
                        credit_q <= credit_q + CRED_W'(1);
                    end
                end
                2'b01:   credit_q <= credit_q - CRED_W'(1);
                default: credit_q <= credit_q;
            endcase
        end
    end

    // Status outputs straight from the registers.
    always_comb begin
        grant_id_o = grant_q;
        credit_o   = credit_q;
        busy_o     = (state_q == ST_XFER);
        err_o      = err_q;
    end

endmodule

// File: tb/tb_qdq_dq_tile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_qdq_dq_tile_arbiter
//
// Purpose:
//   Randomized scoreboard bench for qdq_dq_tile_arbiter. A stimulus process
//   drives random requester valids, dequantizer ready, scale pushes, flushes
//   and one mid-run reset, and advances a tile-level reference model that
//   pushes the expected per-cycle status and the expected accepted beats into
//   queues. A separate monitor pops and compares at every falling edge.
// ---------------------------------------------------------------------------
module tb_qdq_dq_tile_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int LANES_NUM  = 16;
    localparam int FP_DATA_W  = 32;
    localparam int MAT_SIZE   = 16;
    localparam int CREDIT_MAX = 4;
    localparam int BEATS      = (MAT_SIZE * MAT_SIZE + LANES_NUM - 1) / LANES_NUM;
    localparam int ID_W       = $clog2(NUM_REQ);
    localparam int CRED_W     = $clog2(CREDIT_MAX + 1);
    localparam int DATA_W     = LANES_NUM * FP_DATA_W;

    typedef struct {
        logic               dq_valid;
        logic [NUM_REQ-1:0] req_ready;
        logic               tfirst;
        logic               tlast;
        logic [ID_W-1:0]    gid;
        logic [CRED_W-1:0]  credit;
        logic               busy;
        logic               err;
    } status_t;

    logic              clk = 1'b0;
    logic              rstnn;
    logic              flush;
    logic              scl_push;
    logic [ID_W-1:0]   grant_id;
    logic [CRED_W-1:0] credit;
    logic              busy;
    logic              err;

    qdq_dq_tile_arbiter_if #(
        .NUM_REQ   (NUM_REQ),
        .LANES_NUM (LANES_NUM),
        .FP_DATA_W (FP_DATA_W)
    ) bus_if ();

    qdq_dq_tile_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .LANES_NUM  (LANES_NUM),
        .FP_DATA_W  (FP_DATA_W),
        .MAT_SIZE   (MAT_SIZE),
        .CREDIT_MAX (CREDIT_MAX)
    ) dut (
        .clk        (clk),
        .rstnn      (rstnn),
        .flush_i    (flush),
        .scl_push_i (scl_push),
        .bus        (bus_if),
        .grant_id_o (grant_id),
        .credit_o   (credit),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    status_t           status_q[$];
    logic [DATA_W-1:0] beat_q[$];

    // Reference model state, tile-level view.
    int          m_busy;
    int          m_g;
    int          m_beat;
    int          m_gid;
    int          m_credit;
    int          m_rr;
    int          m_err;
    int          src_tile[NUM_REQ];
    logic [31:0] salt[NUM_REQ];

    // Beat payload: each lane tagged with requester, tile, beat and lane.
    function automatic logic [DATA_W-1:0] beatData(input int r, input int tile, input int beat);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int l = 0; l < LANES_NUM; l++) begin
            d[l*FP_DATA_W +: FP_DATA_W] = {8'(r), 8'(tile), 8'(beat), 8'(l)} ^ salt[r];
        end
        return d;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Abandon any tile in flight; a full reset also clears the grant id.
    task automatic modelReset(input bit full);
        if (m_busy != 0) begin
            src_tile[m_g]++;
        end
        m_busy   = 0;
        m_beat   = 0;
        m_credit = 0;
        m_rr     = 0;
        m_err    = 0;
        if (full) begin
            m_gid = 0;
            m_g   = 0;
        end
    endtask

    task automatic applyStimulus(input int pv, input int pr, input int pp, input int pf, input bit rst);
        rstnn = !rst;
        for (int r = 0; r < NUM_REQ; r++) begin
            bus_if.req_valid[r] = ($urandom_range(999) < pv);
            bus_if.req_data[r*DATA_W +: DATA_W] =
                beatData(r, src_tile[r], (m_busy != 0 && m_g == r) ? m_beat : 0);
        end
        bus_if.dq_ready = ($urandom_range(999) < pr);
        scl_push        = ($urandom_range(999) < pp);
        flush           = ($urandom_range(999) < pf);
    endtask

    // Expected outputs for the current cycle, then the state for the next.
    task automatic modelStep();
        status_t s;
        int      pick;
        bit      granted;
        bit      v;
        bit      hs;
        if (!rstnn) begin
            modelReset(1'b1);
        end
        s.dq_valid  = 1'b0;
        s.req_ready = '0;
        s.tfirst    = 1'b0;
        s.tlast     = 1'b0;
        hs          = 1'b0;
        if (m_busy != 0) begin
            v                 = bus_if.req_valid[m_g];
            hs                = v && bus_if.dq_ready;
            s.dq_valid        = v;
            s.req_ready[m_g]  = bus_if.dq_ready;
            s.tfirst          = v && (m_beat == 0);
            s.tlast           = v && (m_beat == BEATS - 1);
            if (hs) begin
                beat_q.push_back(beatData(m_g, src_tile[m_g], m_beat));
            end
        end
        s.gid    = ID_W'(m_gid);
        s.credit = CRED_W'(m_credit);
        s.busy   = (m_busy != 0);
        s.err    = (m_err != 0);
        status_q.push_back(s);

        if (!rstnn) return;
        if (flush) begin
            modelReset(1'b0);
            return;
        end

        granted = 1'b0;
        pick    = 0;
        if (m_busy == 0 && m_credit > 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!granted && bus_if.req_valid[(m_rr + k) % NUM_REQ]) begin
                    granted = 1'b1;
                    pick    = (m_rr + k) % NUM_REQ;
                end
            end
        end
        if (hs) begin
            if (m_beat == BEATS - 1) begin
                m_busy = 0;
                m_beat = 0;
                m_rr   = (m_g + 1) % NUM_REQ;
                src_tile[m_g]++;
            end else begin
                m_beat++;
            end
        end
        if (granted) begin
            m_busy = 1;
            m_g    = pick;
            m_gid  = pick;
            m_beat = 0;
        end
        if (scl_push && !granted) begin
            if (m_credit == CREDIT_MAX) m_err = 1;
            else m_credit++;
        end else if (granted && !scl_push) begin
            m_credit--;
        end
    endtask

    task automatic runPhase(input int n, input int pv, input int pr, input int pp, input int pf, input int rstAt);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(pv, pr, pp, pf, (rstAt >= 0) && (c >= rstAt) && (c < rstAt + 2));
            modelStep();
        end
    endtask

    // Monitor: compare status every cycle; compare payload on each handshake.
    task automatic checkOutput();
        status_t           s;
        logic [DATA_W-1:0] d;
        if (status_q.size() == 0) return;
        s = status_q.pop_front();
        checkVal("dq_valid",  32'(bus_if.dq_valid),  32'(s.dq_valid));
        checkVal("req_ready", 32'(bus_if.req_ready), 32'(s.req_ready));
        checkVal("dq_tfirst", 32'(bus_if.dq_tfirst), 32'(s.tfirst));
        checkVal("dq_tlast",  32'(bus_if.dq_tlast),  32'(s.tlast));
        checkVal("grant_id",  32'(grant_id),         32'(s.gid));
        checkVal("credit",    32'(credit),           32'(s.credit));
        checkVal("busy",      32'(busy),             32'(s.busy));
        checkVal("err",       32'(err),              32'(s.err));
        if (bus_if.dq_valid === 1'b1 && bus_if.dq_ready === 1'b1) begin
            if (beat_q.size() == 0) begin
                checkVal("beat_expected", 32'(1), 32'(0));
            end else begin
                d = beat_q.pop_front();
                tests_run++;
                if (bus_if.dq_data !== d) begin
                    tests_failed++;
                    $display("[TB] FAIL dq_data at %0t: got lane0 %0h, expected lane0 %0h",
                             $time, bus_if.dq_data[31:0], d[31:0]);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    initial begin
        rstnn            = 1'b0;
        flush            = 1'b0;
        scl_push         = 1'b0;
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.dq_ready  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            salt[r]     = $urandom;
            src_tile[r] = 0;
        end
        m_busy = 0;
        m_g    = 0;
        modelReset(1'b1);

        // Reset, then credit saturation with few requests (overflow error).
        runPhase(4, 0, 0, 0, 0, 0);
        runPhase(300, 100, 1000, 600, 0, -1);
        // Back-to-back tiles with all requesters valid: round-robin order.
        runPhase(800, 1000, 1000, 150, 0, -1);
        // Valid/ready gaps mid-tile plus occasional flushes.
        runPhase(1500, 700, 500, 100, 10, -1);
        // Async reset landing in the middle of traffic.
        runPhase(1200, 400, 800, 250, 0, 600);
        // Busy traffic with more frequent flushes.
        runPhase(1500, 900, 900, 80, 20, -1);
        // Quiet tail so everything outstanding drains through the monitor.
        runPhase(5, 0, 0, 0, 0, -1);

        @(negedge clk);
        #1;
        checkVal("status_queue_drained", 32'(status_q.size()), 32'(0));
        checkVal("beat_queue_drained",   32'(beat_q.size()),   32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
